// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_arbiter                                                  |
// | Description : Two-requester arbiter in front of a shared combinational ALU.|
// |               Optional round-robin arbitration via macro ALU_ARB_RR_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_aluop,
  input  logic [3:0]       req0_funct,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_aluop,
  input  logic [3:0]       req1_funct,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_CTRL_ILLEGAL = 4'b1111;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_alu_ctrl;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_err;

  logic             w_pick1;
  logic             w_can_accept;
  logic             w_accept;
  logic [1:0]       w_aluop;
  logic [3:0]       w_funct;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [3:0]       w_ctrl;
  logic             w_illegal;

  function automatic logic [3:0] decode(input logic [1:0] aluop, input logic [3:0] funct);
    logic [3:0] ctrl;
    ctrl = c_CTRL_ILLEGAL;
    case (aluop)
      2'b00: ctrl = 4'b0010;
      2'b01: ctrl = 4'b0110;
      2'b10: begin
        case (funct)
          4'b1000: ctrl = 4'b0110;
          4'b0000: ctrl = 4'b0010;
          4'b0111: ctrl = 4'b0001;
          4'b0110: ctrl = 4'b0000;
          default: ctrl = c_CTRL_ILLEGAL;
        endcase
      end
      default: ctrl = 4'b0000;
    endcase
    return ctrl;
  endfunction

`ifdef ALU_ARB_RR_EN
  // Pointer holds the id of the last granted requester; the other one wins a tie.
  logic r_last;

  assign w_pick1 = req1_valid & (~req0_valid | ~r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_pick1;
    end
  end
`else
  assign w_pick1 = req1_valid & ~req0_valid;
`endif

  assign w_can_accept = ~rst & ((r_state == S_IDLE) | ((r_state == S_RESP) & rsp_ready));
  assign w_accept     = w_can_accept & (req0_valid | req1_valid);
  assign req0_ready   = w_can_accept & req0_valid & ~w_pick1;
  assign req1_ready   = w_can_accept & w_pick1;

  assign w_aluop   = w_pick1 ? req1_aluop : req0_aluop;
  assign w_funct   = w_pick1 ? req1_funct : req0_funct;
  assign w_a       = w_pick1 ? req1_a     : req0_a;
  assign w_b       = w_pick1 ? req1_b     : req0_b;
  assign w_ctrl    = decode(w_aluop, w_funct);
  assign w_illegal = (w_ctrl == c_CTRL_ILLEGAL);

  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      w_next = w_illegal ? S_RESP : S_EXEC;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_EXEC:  w_next = S_RESP;
        S_RESP:  w_next = rsp_ready ? S_IDLE : S_RESP;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Illegal ops never reach the ALU registers, so alu_ctrl cannot carry 1111.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_ctrl   <= 4'b0000;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
    end else if (w_accept) begin
      r_rsp_id <= w_pick1;
      if (w_illegal) begin
        r_rsp_result <= '0;
        r_rsp_err    <= 1'b1;
      end else begin
        r_alu_ctrl <= w_ctrl;
        r_alu_a    <= w_a;
        r_alu_b    <= w_b;
        r_rsp_err  <= 1'b0;
      end
    end else if (r_state == S_EXEC) begin
      r_rsp_result <= alu_result;
    end
  end

  assign alu_ctrl   = r_alu_ctrl;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire
